// File: rtl/time_count_module_pkg.sv
// Shared constants, types and BCD helpers for the clock timekeeping stage.
package time_count_module_pkg;

    localparam int unsigned PRESC_W = 26;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SEG_W   = 8;
    localparam int unsigned DP_BIT  = 7;

    // Active-low segment codes: bit7 = dp, bits6:0 = g..a
    localparam logic [SEG_W-1:0] SEG_0     = 8'hC0;
    localparam logic [SEG_W-1:0] SEG_1     = 8'hF9;
    localparam logic [SEG_W-1:0] SEG_2     = 8'hA4;
    localparam logic [SEG_W-1:0] SEG_3     = 8'hB0;
    localparam logic [SEG_W-1:0] SEG_4     = 8'h99;
    localparam logic [SEG_W-1:0] SEG_5     = 8'h92;
    localparam logic [SEG_W-1:0] SEG_6     = 8'h82;
    localparam logic [SEG_W-1:0] SEG_7     = 8'hF8;
    localparam logic [SEG_W-1:0] SEG_8     = 8'h80;
    localparam logic [SEG_W-1:0] SEG_9     = 8'h90;
    localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

    // Terminal digits of each field
    localparam logic [DIGIT_W-1:0] MS_TEN_MAX   = 4'd5;
    localparam logic [DIGIT_W-1:0] MS_ONE_MAX   = 4'd9;
    localparam logic [DIGIT_W-1:0] HOUR_TEN_MAX = 4'd2;
    localparam logic [DIGIT_W-1:0] HOUR_ONE_MAX = 4'd3;

    typedef enum logic [1:0] {
        MODE_NORMAL   = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2
    } mode_e;

    typedef struct packed {
        logic [DIGIT_W-1:0] ten;
        logic [DIGIT_W-1:0] one;
    } bcd2_t;

    // True when the two-digit field sits on its last value before wrapping
    function automatic logic bcd_at_max(input bcd2_t v, input logic [DIGIT_W-1:0] ten_max,
                                        input logic [DIGIT_W-1:0] one_max);
        return (v.ten == ten_max) && (v.one == one_max);
    endfunction

    // Two-digit BCD increment that wraps to 00 after {ten_max, one_max}
    function automatic bcd2_t bcd_inc(input bcd2_t v, input logic [DIGIT_W-1:0] ten_max,
                                      input logic [DIGIT_W-1:0] one_max);
        bcd2_t r;
        if (bcd_at_max(v, ten_max, one_max)) begin
            r = '0;
        end else if (v.one == 4'd9) begin
            r.ten = v.ten + 4'd1;
            r.one = '0;
        end else begin
            r.ten = v.ten;
            r.one = v.one + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/smg_encode_module.sv
// BCD digit to active-low 7-segment code with the dp off.
module smg_encode_module
    import time_count_module_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [SEG_W-1:0]   seg
);

    // Digit lookup; non-decimal codes show blank
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/time_count_module.sv
// HH:MM:SS BCD timekeeper with hour/minute set mode and registered 7-segment outputs.
module time_count_module
    import time_count_module_pkg::*;
#(
    parameter logic [PRESC_W-1:0] T1S   = 26'd49_999_999,
    parameter logic [PRESC_W-1:0] THALF = 26'd24_999_999
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Set_Key,
    input  logic             Inc_Key,
    output logic [SEG_W-1:0] Ten_SMG_Data0,
    output logic [SEG_W-1:0] One_SMG_Data0,
    output logic [SEG_W-1:0] Ten_SMG_Data1,
    output logic [SEG_W-1:0] One_SMG_Data1,
    output logic [SEG_W-1:0] Ten_SMG_Data2,
    output logic [SEG_W-1:0] One_SMG_Data2,
    output logic             Sec_Tick
);

    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] presc_next;
    logic               tick_now;
    logic               leave_set;
    logic               phase;
    mode_e              mode;
    bcd2_t              hour;
    bcd2_t              minute;
    bcd2_t              second;

    logic [SEG_W-1:0] seg_h_ten, seg_h_one, seg_m_ten, seg_m_one, seg_s_ten, seg_s_one;
    logic             blink_h, blink_m, colon;

    // Prescaler next value; leaving set mode restarts the second
    always_comb begin
        tick_now   = (presc == T1S);
        leave_set  = (mode == MODE_SET_MIN) && Set_Key;
        presc_next = (leave_set || tick_now) ? '0 : presc + PRESC_W'(1);
        phase      = (presc >= THALF);
        blink_h    = (mode == MODE_SET_HOUR) && phase;
        blink_m    = (mode == MODE_SET_MIN) && phase;
        colon      = (mode == MODE_NORMAL) && !phase;
    end

    // Prescaler and its registered wrap pulse
    always_ff @(posedge CLK) begin
        if (RST) begin
            presc    <= '0;
            Sec_Tick <= 1'b0;
        end else begin
            presc    <= presc_next;
            Sec_Tick <= (presc_next == T1S);
        end
    end

    // Mode FSM and BCD time counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            mode   <= MODE_NORMAL;
            hour   <= '0;
            minute <= '0;
            second <= '0;
        end else begin
            if (Set_Key) begin
                case (mode)
                    MODE_NORMAL:   mode <= MODE_SET_HOUR;
                    MODE_SET_HOUR: mode <= MODE_SET_MIN;
                    default: begin
                        mode   <= MODE_NORMAL;
                        second <= '0;
                    end
                endcase
            end else if (Inc_Key) begin
                if (mode == MODE_SET_HOUR) begin
                    hour <= bcd_inc(hour, HOUR_TEN_MAX, HOUR_ONE_MAX);
                end else if (mode == MODE_SET_MIN) begin
                    minute <= bcd_inc(minute, MS_TEN_MAX, MS_ONE_MAX);
                end
            end
            if ((mode == MODE_NORMAL) && tick_now) begin
                second <= bcd_inc(second, MS_TEN_MAX, MS_ONE_MAX);
                if (bcd_at_max(second, MS_TEN_MAX, MS_ONE_MAX)) begin
                    minute <= bcd_inc(minute, MS_TEN_MAX, MS_ONE_MAX);
                    if (bcd_at_max(minute, MS_TEN_MAX, MS_ONE_MAX)) begin
                        hour <= bcd_inc(hour, HOUR_TEN_MAX, HOUR_ONE_MAX);
                    end
                end
            end
        end
    end

    smg_encode_module u_enc_h_ten (.digit(hour.ten),   .seg(seg_h_ten));
    smg_encode_module u_enc_h_one (.digit(hour.one),   .seg(seg_h_one));
    smg_encode_module u_enc_m_ten (.digit(minute.ten), .seg(seg_m_ten));
    smg_encode_module u_enc_m_one (.digit(minute.one), .seg(seg_m_one));
    smg_encode_module u_enc_s_ten (.digit(second.ten), .seg(seg_s_ten));
    smg_encode_module u_enc_s_one (.digit(second.one), .seg(seg_s_one));

    // Output registers with blink and colon overlays
    always_ff @(posedge CLK) begin
        if (RST) begin
            Ten_SMG_Data0 <= SEG_0;
            One_SMG_Data0 <= SEG_0;
            Ten_SMG_Data1 <= SEG_0;
            One_SMG_Data1 <= SEG_0;
            Ten_SMG_Data2 <= SEG_0;
            One_SMG_Data2 <= SEG_0;
        end else begin
            Ten_SMG_Data0 <= blink_h ? SEG_BLANK : seg_h_ten;
            One_SMG_Data0 <= blink_h ? SEG_BLANK
                                     : {seg_h_one[DP_BIT] & ~colon, seg_h_one[DP_BIT-1:0]};
            Ten_SMG_Data1 <= blink_m ? SEG_BLANK : seg_m_ten;
            One_SMG_Data1 <= blink_m ? SEG_BLANK
                                     : {seg_m_one[DP_BIT] & ~colon, seg_m_one[DP_BIT-1:0]};
            Ten_SMG_Data2 <= seg_s_ten;
            One_SMG_Data2 <= seg_s_one;
        end
    end

endmodule
